psum_beta_stack: RTL

- Partial-sum (beta) combiner directly downstream of the SPC/rate-1/repetition leaf decoders in the fast-SSC polar decoder.
- Accepts hard-decision leaf codewords, up to 16 bits, on the same bit bus the SPC node produces.
- Keeps left-child betas on a small stack until the right sibling arrives, then folds each pair upward with beta = {r, l^r}.
- Exposes the stack top to the g-function datapath; emits the final combined beta for the frame or subtree.

---
 rtl/psum_beta_stack_pkg.sv | 14 +
 rtl/psum_beta_stack_combine.sv | 23 ++
 rtl/psum_beta_stack.sv | 129 ++++++++++++
 3 files changed

// File: rtl/psum_beta_stack_pkg.sv
// Shared sizing and state encoding for the polar partial-sum (beta) combiner.
package psum_beta_stack_pkg;
  localparam int LEAF_W   = 16;
  localparam int MAX_LOG2 = 7;
  localparam int DEPTH    = MAX_LOG2 - 2;
  localparam int BETA_W   = 1 << MAX_LOG2;
  localparam int SP_W     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMB = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/psum_beta_stack_combine.sv
// Polar fold of a left/right sibling pair: beta = {r, l^r} at twice the input length.
module beta_combine
  import psum_beta_stack_pkg::*;
(
  input  logic [BETA_W-1:0] l,
  input  logic [BETA_W-1:0] r,
  input  logic [2:0]        len_log2,
  output logic [BETA_W-1:0] beta
);
  logic [BETA_W-1:0] cand [8];

  // One candidate per length; lengths that cannot double inside the bus pass r through.
  for (genvar k = 0; k < 8; k++) begin : g_len
    if (k < MAX_LOG2) begin : g_fold
      localparam int N = 1 << k;
      assign cand[k] = BETA_W'({r[N-1:0], l[N-1:0] ^ r[N-1:0]});
    end else begin : g_pass
      assign cand[k] = r;
    end
  end

  assign beta = cand[len_log2];
endmodule

// File: rtl/psum_beta_stack.sv
// Beta stack: holds left-child betas until the right sibling arrives, folds pairs upward.
module psum_beta_stack
  import psum_beta_stack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEAF_W-1:0] in_bits,
  input  logic [2:0]        in_len_log2,
  input  logic [2:0]        in_comb,
  input  logic              in_final,
  output logic [BETA_W-1:0] top_beta,
  output logic [2:0]        top_len_log2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BETA_W-1:0] out_beta,
  output logic [2:0]        out_len_log2,
  output logic              err
);
  state_t            state;
  logic [BETA_W-1:0] stk_data [DEPTH];
  logic [2:0]        stk_len  [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   top_idx;
  logic [BETA_W-1:0] work;
  logic [2:0]        wlen;
  logic [2:0]        cnt;
  logic              final_q;
  logic [BETA_W-1:0] comb_beta;
  logic              comb_bad;

  assign top_idx      = (sp == '0) ? '0 : sp - SP_W'(1);
  assign top_beta     = (sp == '0) ? '0 : stk_data[top_idx];
  assign top_len_log2 = (sp == '0) ? '0 : stk_len[top_idx];
  assign in_ready     = (state == IDLE);
  assign out_beta     = out_valid ? work : '0;
  assign out_len_log2 = out_valid ? wlen : '0;

  assign comb_bad = (sp == '0) || (stk_len[top_idx] != wlen) || (wlen == 3'(MAX_LOG2));

  beta_combine u_comb (
    .l        (stk_data[top_idx]),
    .r        (work),
    .len_log2 (wlen),
    .beta     (comb_beta)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= '0;
      work      <= '0;
      wlen      <= '0;
      cnt       <= '0;
      final_q   <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_data[i] <= '0;
        stk_len[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Clear precedes the accept so a leaf can start a new frame on the same edge.
          if (frame_start) begin
            sp  <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              stk_data[i] <= '0;
              stk_len[i]  <= '0;
            end
          end
          if (in_valid) begin
            work    <= BETA_W'(in_bits);
            wlen    <= in_len_log2;
            cnt     <= in_comb;
            final_q <= in_final;
            if (in_comb != 3'd0) begin
              state <= COMB;
            end else begin
              state     <= FIN;
              out_valid <= in_final;
            end
          end
        end
        COMB: begin
          if (comb_bad) begin
            err       <= 1'b1;
            cnt       <= '0;
            state     <= FIN;
            out_valid <= final_q;
          end else begin
            work              <= comb_beta;
            wlen              <= wlen + 3'd1;
            sp                <= sp - SP_W'(1);
            stk_data[top_idx] <= '0;
            stk_len[top_idx]  <= '0;
            cnt               <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state     <= FIN;
              out_valid <= final_q;
            end
          end
        end
        FIN: begin
          if (final_q) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            if (sp < SP_W'(DEPTH)) begin
              stk_data[sp] <= work;
              stk_len[sp]  <= wlen;
              sp           <= sp + SP_W'(1);
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
